control_unit: RTL and testbench
===============================

# control_unit

Multicycle control unit that sequences the `cpu` datapath (register file, ALU, operand/writeback muxes, data memory). It accepts one 32-bit RV64 instruction at a time through a valid/ready handshake and decodes it. It then drives every `cpu_*` control input for the instruction's cycle sequence, pulsing a write enable only after addresses, immediate and mux selects have been stable for at least one full cycle. Supported subset: `ld`, `sd`, `addi`, `add`, `sub`, `and`, `or`.

## Interface
- `WORDSIZE`, 64, datapath width; width of the sign-extended immediate.
- `CNTSIZE`, 16, width of the retired-instruction counter.

Ports, clock and reset first:
- `cu_clk`  in  1  single clock; all state changes on the rising edge.
- `cu_reset`  in  1  asynchronous, active-high reset.
- `cu_instr`  in  32  instruction word; sampled on handshake.
- `cu_instr_valid`  in  1  `cu_instr` is valid.
- `cu_instr_ready`  out  1  unit can accept an instruction.
- `cu_rf_addr_a`  out  5  to `cpu_rf_addr_a`.
- `cu_rf_addr_b`  out  5  to `cpu_rf_addr_b`.
- `cu_rf_write_addr`  out  5  to `cpu_rf_write_addr`.
- `cu_rf_write_en`  out  1  to `cpu_rf_write_en`.
- `cu_immediate`  out  WORDSIZE  to `cpu_immediate`; sign-extended.
- `cu_mux_0_sel`  out  1  ALU A source: 0 = rf data a, 1 = rf data b.
- `cu_mux_1_sel`  out  1  ALU B source: 0 = immediate, 1 = rf data b.
- `cu_mux_2_sel`  out  1  RF write-data source: 0 = ALU result, 1 = DM output.
- `cu_alu_operation`  out  3  000 add, 001 sub, 010 and, 011 or.
- `cu_dm_write_en`  out  1  to `cpu_dm_write_en`.
- `cu_done`  out  1  one-cycle pulse when an instruction retires.
- `cu_error`  out  1  sticky; set on an illegal instruction.
- `cu_retired`  out  CNTSIZE  count of retired instructions.

## Operation
- **Decode set:**
  - `ld`: opcode 0000011, f3 011.
  - `sd`: opcode 0100011, f3 011.
  - `addi`: opcode 0010011, f3 000.
  - R-type (opcode 0110011): `add` f3 000 / f7 0000000; `sub` f3 000 / f7 0100000; `and` f3 111 / f7 0; `or` f3 110 / f7 0.
  - Anything else is illegal.
- **Immediates:**
  - I-type: `instr[31:20]`.
  - S-type: `{instr[31:25], instr[11:7]}`.
  - Both sign-extended to WORDSIZE. R-type immediate is 0.
- **Control mapping:**
  - `ld`: addr_a = rs1, addr_b = rs2 field, mux0 = 0, mux1 = 0, alu = add, mux2 = 1, write_addr = rd.
  - `addi`: same as `ld` except mux2 = 0.
  - R-type: addr_a = rs1, addr_b = rs2, mux0 = 0, mux1 = 1, mux2 = 0, alu per funct, write_addr = rd.
  - `sd`: addr_a = rs2 (store data), addr_b = rs1 (base), mux0 = 1, mux1 = 0, alu = add, write_addr = 0.
- **States:** IDLE, DECODE, EXEC, MEM, WB, ERR.
  - IDLE: `cu_instr_ready` = 1. On valid && ready, latch the instruction and go to DECODE.
  - DECODE: drive addresses, immediate and selects with all enables 0.
    - Illegal instruction -> ERR.
    - `ld` -> MEM.
    - Otherwise -> EXEC.
  - EXEC: selects held.
    - `sd`: `cu_dm_write_en` = 1.
    - `addi`/R-type: `cu_rf_write_en` = 1, unless rd = x0.
    - Assert `cu_done`, then go to IDLE.
  - MEM (`ld` only): selects held, enables 0 (DM read settles) -> WB.
  - WB: `cu_rf_write_en` = 1 (unless rd = x0), `cu_done` = 1 -> IDLE.
  - ERR: `cu_error` <= 1, no enables, no `cu_done`, no count -> IDLE.
- `cu_retired` increments by 1 on each `cu_done`; wraps from 2^CNTSIZE-1 to 0.
- Control outputs keep their last decoded values while in IDLE; enables are always 0 in IDLE.

## Timing
- **Reset values:**
  - `cu_instr_ready` = 0 while `cu_reset` is high, then 1 in IDLE.
  - All other outputs = 0. State = IDLE.
- **Reset mid-operation:** the instruction is abandoned with no enable pulse and no count. `cu_error` clears.
- **Latency from the handshake edge:**
  - `sd`/`addi`/R-type: enable and `cu_done` in cycle 2.
  - `ld`: RF write and `cu_done` in cycle 3.
  - Illegal: back in IDLE at cycle 3.
- **Throughput:**
  - `cu_instr_ready` is low from the cycle after acceptance until return to IDLE.
  - `cu_instr_valid` while not ready is ignored; the source holds it.
  - Back-to-back accept is possible on the first IDLE cycle.
- **Enable pulses:** each enable is exactly one cycle wide. `cu_rf_write_en` and `cu_dm_write_en` are never high together.
- **Stability:** addresses, immediate and selects do not change in any cycle where an enable is high.

## Test plan
- `ld x2,5(x7)` = 0x0053B103 -> DECODE: addr_a = 7, imm = 5, mux2 = 1. MEM: no enables. WB: `rf_write_en` = 1, write_addr = 2, `cu_done` = 1, `cu_retired` = 1.
- `sd x4,23(x2)` = 0x00413BA3 -> addr_a = 4, addr_b = 2, mux0 = 1, mux1 = 0, imm = 0x17. `dm_write_en` pulses 1 cycle in cycle 2; `rf_write_en` stays 0.
- `sub x5,x1,x3` = 0x403082B3 -> alu = 001, mux1 = 1, addr_b = 3, write_addr = 5. Write in cycle 2.
- `addi x0,x1,-1` = 0xFFF08013 -> imm = 0xFFFF_FFFF_FFFF_FFFF. `rf_write_en` never high; `cu_done` pulses.
- Illegal 0x00000000 -> `cu_error` = 1 and stays set through a following legal `add`. No enables, `cu_retired` unchanged.
- Assert `cu_reset` during MEM of `ld` -> no `rf_write_en`, all outputs 0. `cu_instr_ready` = 1 one cycle after release.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multicycle sequencer for the cpu datapath. It accepts one
// instruction per handshake and supports ld, sd, addi, add, sub, and, or.
module control_unit #(
  parameter int WORDSIZE = 64,
  parameter int CNTSIZE  = 16
) (
  input  logic                cu_clk,
  input  logic                cu_reset,
  input  logic [31:0]         cu_instr,
  input  logic                cu_instr_valid,
  output logic                cu_instr_ready,
  output logic [4:0]          cu_rf_addr_a,
  output logic [4:0]          cu_rf_addr_b,
  output logic [4:0]          cu_rf_write_addr,
  output logic                cu_rf_write_en,
  output logic [WORDSIZE-1:0] cu_immediate,
  output logic                cu_mux_0_sel,
  output logic                cu_mux_1_sel,
  output logic                cu_mux_2_sel,
  output logic [2:0]          cu_alu_operation,
  output logic                cu_dm_write_en,
  output logic                cu_done,
  output logic                cu_error,
  output logic [CNTSIZE-1:0]  cu_retired
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, ERR} state_e;
  typedef enum logic [1:0] {KIND_ILLEGAL, KIND_LOAD, KIND_STORE, KIND_ALU} kind_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  state_e state_q, state_d;
  kind_e  kind_q;

  logic [4:0]          addrA_q, addrB_q, wAddr_q;
  logic [WORDSIZE-1:0] imm_q;
  logic                mux0_q, mux1_q, mux2_q;
  logic [2:0]          alu_q;
  logic                error_q;
  logic [CNTSIZE-1:0]  retired_q;
  logic                live_q;

  kind_e               decKind;
  logic [4:0]          decAddrA, decAddrB, decWAddr;
  logic [WORDSIZE-1:0] decImm;
  logic                decMux0, decMux1, decMux2;
  logic [2:0]          decAlu;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [WORDSIZE-1:0] immI, immS;

  logic accept;
  logic rfWe, dmWe, done;

  assign opcode = cu_instr[6:0];
  assign funct3 = cu_instr[14:12];
  assign funct7 = cu_instr[31:25];
  assign immI   = {{(WORDSIZE-12){cu_instr[31]}}, cu_instr[31:20]};
  assign immS   = {{(WORDSIZE-12){cu_instr[31]}}, cu_instr[31:25], cu_instr[11:7]};

  // live_q holds ready low for the cycle spent in reset and releases it on the first edge after.
  assign cu_instr_ready = (state_q == IDLE) && live_q;
  assign accept         = cu_instr_valid && cu_instr_ready;

  // Decode straight from the incoming word so the selects are already valid in DECODE.
  always_comb begin
    decKind  = KIND_ILLEGAL;
    decAddrA = 5'd0;
    decAddrB = 5'd0;
    decWAddr = 5'd0;
    decImm   = '0;
    decMux0  = 1'b0;
    decMux1  = 1'b0;
    decMux2  = 1'b0;
    decAlu   = ALU_ADD;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == 3'b011) begin
          decKind  = KIND_LOAD;
          decAddrA = cu_instr[19:15];
          decAddrB = cu_instr[24:20];
          decWAddr = cu_instr[11:7];
          decImm   = immI;
          decMux2  = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b011) begin
          decKind  = KIND_STORE;
          decAddrA = cu_instr[24:20];
          decAddrB = cu_instr[19:15];
          decImm   = immS;
          decMux0  = 1'b1;
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          decKind  = KIND_ALU;
          decAddrA = cu_instr[19:15];
          decAddrB = cu_instr[24:20];
          decWAddr = cu_instr[11:7];
          decImm   = immI;
        end
      end
      OP_REG: begin
        decAddrA = cu_instr[19:15];
        decAddrB = cu_instr[24:20];
        decWAddr = cu_instr[11:7];
        decMux1  = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          decKind = KIND_ALU;
          decAlu  = ALU_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          decKind = KIND_ALU;
          decAlu  = ALU_SUB;
        end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
          decKind = KIND_ALU;
          decAlu  = ALU_AND;
        end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
          decKind = KIND_ALU;
          decAlu  = ALU_OR;
        end
      end
      default: decKind = KIND_ILLEGAL;
    endcase
  end

  always_ff @(posedge cu_clk or posedge cu_reset) begin
    if (cu_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DECODE;
      end
      DECODE: begin
        if (kind_q == KIND_ILLEGAL)   state_d = ERR;
        else if (kind_q == KIND_LOAD) state_d = MEM;
        else                          state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      MEM:     state_d = WB;
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd = x0 suppresses the register-file write but the instruction still retires.
  always_comb begin
    rfWe = 1'b0;
    dmWe = 1'b0;
    done = 1'b0;
    case (state_q)
      EXEC: begin
        done = 1'b1;
        if (kind_q == KIND_STORE) dmWe = 1'b1;
        else if (kind_q == KIND_ALU && wAddr_q != 5'd0) rfWe = 1'b1;
      end
      WB: begin
        done = 1'b1;
        if (wAddr_q != 5'd0) rfWe = 1'b1;
      end
      default: begin
        rfWe = 1'b0;
        dmWe = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cu_clk or posedge cu_reset) begin
    if (cu_reset) begin
      kind_q  <= KIND_ILLEGAL;
      addrA_q <= 5'd0;
      addrB_q <= 5'd0;
      wAddr_q <= 5'd0;
      imm_q   <= '0;
      mux0_q  <= 1'b0;
      mux1_q  <= 1'b0;
      mux2_q  <= 1'b0;
      alu_q   <= ALU_ADD;
    end else if (accept) begin
      kind_q  <= decKind;
      addrA_q <= decAddrA;
      addrB_q <= decAddrB;
      wAddr_q <= decWAddr;
      imm_q   <= decImm;
      mux0_q  <= decMux0;
      mux1_q  <= decMux1;
      mux2_q  <= decMux2;
      alu_q   <= decAlu;
    end
  end

  always_ff @(posedge cu_clk or posedge cu_reset) begin
    if (cu_reset) begin
      live_q    <= 1'b0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (state_q == ERR) error_q <= 1'b1;
      if (done) retired_q <= retired_q + {{(CNTSIZE-1){1'b0}}, 1'b1};
    end
  end

  assign cu_rf_addr_a     = addrA_q;
  assign cu_rf_addr_b     = addrB_q;
  assign cu_rf_write_addr = wAddr_q;
  assign cu_immediate     = imm_q;
  assign cu_mux_0_sel     = mux0_q;
  assign cu_mux_1_sel     = mux1_q;
  assign cu_mux_2_sel     = mux2_q;
  assign cu_alu_operation = alu_q;
  assign cu_rf_write_en   = rfWe;
  assign cu_dm_write_en   = dmWe;
  assign cu_done          = done;
  assign cu_error         = error_q;
  assign cu_retired       = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table plus hand sequences for
// back-to-back acceptance and reset during a load.
module tb_control_unit;

  logic        cu_clk;
  logic        cu_reset;
  logic [31:0] cu_instr;
  logic        cu_instr_valid;
  logic        cu_instr_ready;
  logic [4:0]  cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
  logic        cu_rf_write_en;
  logic [63:0] cu_immediate;
  logic        cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel;
  logic [2:0]  cu_alu_operation;
  logic        cu_dm_write_en;
  logic        cu_done;
  logic        cu_error;
  logic [15:0] cu_retired;

  int compared   = 0;
  int mismatched = 0;
  int expRetired = 0;
  logic expError = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        illegal;
    logic [4:0]  addrA, addrB, wAddr;
    logic [63:0] imm;
    logic        mux0, mux1, mux2;
    logic [2:0]  alu;
    int          rfCycle, dmCycle, doneCycle, busy;
  } vec_t;

  vec_t vecs[14];

  logic [84:0]  dutFields;
  logic [105:0] allOut;

  assign dutFields = {cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr, cu_immediate,
                      cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation};
  assign allOut    = {cu_instr_ready, cu_rf_write_en, cu_dm_write_en, cu_done,
                      cu_error, cu_retired, dutFields};

  control_unit dut (
    .cu_clk           (cu_clk),
    .cu_reset         (cu_reset),
    .cu_instr         (cu_instr),
    .cu_instr_valid   (cu_instr_valid),
    .cu_instr_ready   (cu_instr_ready),
    .cu_rf_addr_a     (cu_rf_addr_a),
    .cu_rf_addr_b     (cu_rf_addr_b),
    .cu_rf_write_addr (cu_rf_write_addr),
    .cu_rf_write_en   (cu_rf_write_en),
    .cu_immediate     (cu_immediate),
    .cu_mux_0_sel     (cu_mux_0_sel),
    .cu_mux_1_sel     (cu_mux_1_sel),
    .cu_mux_2_sel     (cu_mux_2_sel),
    .cu_alu_operation (cu_alu_operation),
    .cu_dm_write_en   (cu_dm_write_en),
    .cu_done          (cu_done),
    .cu_error         (cu_error),
    .cu_retired       (cu_retired)
  );

  initial cu_clk = 1'b0;
  always #5 cu_clk = ~cu_clk;

  function automatic vec_t mk(string name, logic [31:0] instr, logic illegal,
                              logic [4:0] a, logic [4:0] b, logic [4:0] w,
                              logic [63:0] imm, logic m0, logic m1, logic m2,
                              logic [2:0] alu, int rfC, int dmC, int doneC, int busy);
    vec_t v;
    v.name = name; v.instr = instr; v.illegal = illegal;
    v.addrA = a; v.addrB = b; v.wAddr = w; v.imm = imm;
    v.mux0 = m0; v.mux1 = m1; v.mux2 = m2; v.alu = alu;
    v.rfCycle = rfC; v.dmCycle = dmC; v.doneCycle = doneC; v.busy = busy;
    return v;
  endfunction

  function automatic logic [84:0] packFields(vec_t v);
    return {v.addrA, v.addrB, v.wAddr, v.imm, v.mux0, v.mux1, v.mux2, v.alu};
  endfunction

  task automatic checkOutput(string name, logic [127:0] actual, logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitReady(string name);
    int n = 0;
    while (cu_instr_ready !== 1'b1 && n < 20) begin
      @(posedge cu_clk); #1;
      n++;
    end
    if (cu_instr_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s ready timeout: got %b, expected 1", name, cu_instr_ready);
    end
  endtask

  // Cycle c counts periods after the handshake edge; fields are rechecked whenever an enable is up.
  task automatic applyStimulus(input vec_t v);
    waitReady(v.name);
    cu_instr       = v.instr;
    cu_instr_valid = 1'b1;
    @(posedge cu_clk); #1;
    cu_instr_valid = 1'b0;
    cu_instr       = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        @(posedge cu_clk); #1;
      end
      checkOutput($sformatf("%s flags c%0d", v.name, c),
                  {cu_rf_write_en, cu_dm_write_en, cu_done, cu_instr_ready},
                  {(c == v.rfCycle), (c == v.dmCycle), (c == v.doneCycle), (c > v.busy)});
      if (!v.illegal && (c == 1 || c == 4 || c == v.rfCycle || c == v.dmCycle))
        checkOutput($sformatf("%s fields c%0d", v.name, c), dutFields, packFields(v));
    end
    if (v.illegal) expError = 1'b1;
    else expRetired++;
    checkOutput({v.name, " retired"}, cu_retired, expRetired[15:0]);
    checkOutput({v.name, " error"}, cu_error, expError);
  endtask

  initial begin
    vecs[0]  = mk("ld x2,5(x7)",   32'h0053B103, 0, 5'd7,  5'd5,  5'd2,  64'h5,                 0, 0, 1, 3'd0, 3, 0, 3, 3);
    vecs[1]  = mk("sd x4,23(x2)",  32'h00413BA3, 0, 5'd4,  5'd2,  5'd0,  64'h17,                1, 0, 0, 3'd0, 0, 2, 2, 2);
    vecs[2]  = mk("sub x5,x1,x3",  32'h403082B3, 0, 5'd1,  5'd3,  5'd5,  64'h0,                 0, 1, 0, 3'd1, 2, 0, 2, 2);
    vecs[3]  = mk("addi x0,x1,-1", 32'hFFF08013, 0, 5'd1,  5'd31, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3'd0, 0, 0, 2, 2);
    vecs[4]  = mk("add x3,x1,x2",  32'h002081B3, 0, 5'd1,  5'd2,  5'd3,  64'h0,                 0, 1, 0, 3'd0, 2, 0, 2, 2);
    vecs[5]  = mk("and x6,x7,x8",  32'h0083F333, 0, 5'd7,  5'd8,  5'd6,  64'h0,                 0, 1, 0, 3'd2, 2, 0, 2, 2);
    vecs[6]  = mk("or x31,x30,x29",32'h01DF6FB3, 0, 5'd30, 5'd29, 5'd31, 64'h0,                 0, 1, 0, 3'd3, 2, 0, 2, 2);
    vecs[7]  = mk("ld x9,-8(x10)", 32'hFF853483, 0, 5'd10, 5'd24, 5'd9,  64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 3'd0, 3, 0, 3, 3);
    vecs[8]  = mk("sd x31,-1(x0)", 32'hFFF03FA3, 0, 5'd31, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 3'd0, 0, 2, 2, 2);
    vecs[9]  = mk("illegal zero",  32'h00000000, 1, 5'd0,  5'd0,  5'd0,  64'h0,                 0, 0, 0, 3'd0, 0, 0, 0, 2);
    vecs[10] = mk("add x1,x2,x3",  32'h003100B3, 0, 5'd2,  5'd3,  5'd1,  64'h0,                 0, 1, 0, 3'd0, 2, 0, 2, 2);
    vecs[11] = mk("illegal f7",    32'h202081B3, 1, 5'd0,  5'd0,  5'd0,  64'h0,                 0, 0, 0, 3'd0, 0, 0, 0, 2);
    vecs[12] = mk("illegal lw",    32'h0053A103, 1, 5'd0,  5'd0,  5'd0,  64'h0,                 0, 0, 0, 3'd0, 0, 0, 0, 2);
    vecs[13] = mk("sub x0,x1,x3",  32'h40308033, 0, 5'd1,  5'd3,  5'd0,  64'h0,                 0, 1, 0, 3'd1, 0, 0, 2, 2);

    cu_reset       = 1'b1;
    cu_instr       = 32'h0;
    cu_instr_valid = 1'b0;
    #1;
    checkOutput("reset outputs", allOut, 106'd0);
    repeat (2) @(posedge cu_clk);
    #1;
    checkOutput("reset ready held low", cu_instr_ready, 1'b0);
    @(negedge cu_clk);
    cu_reset = 1'b0;
    @(posedge cu_clk); #1;
    checkOutput("ready after reset", allOut, {1'b1, 105'd0});

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Back-to-back: valid held high while busy must be ignored, then taken on the first IDLE cycle.
    waitReady("b2b");
    cu_instr       = 32'h002081B3;
    cu_instr_valid = 1'b1;
    @(posedge cu_clk); #1;
    cu_instr = 32'h403082B3;
    checkOutput("b2b c1", {cu_instr_ready, cu_rf_write_addr}, {1'b0, 5'd3});
    @(posedge cu_clk); #1;
    checkOutput("b2b c2", {cu_rf_write_en, cu_done, cu_instr_ready, cu_rf_write_addr, cu_alu_operation},
                {1'b1, 1'b1, 1'b0, 5'd3, 3'd0});
    @(posedge cu_clk); #1;
    checkOutput("b2b c3", {cu_rf_write_en, cu_done, cu_instr_ready, cu_rf_write_addr},
                {1'b0, 1'b0, 1'b1, 5'd3});
    @(posedge cu_clk); #1;
    cu_instr_valid = 1'b0;
    checkOutput("b2b c4", {cu_instr_ready, cu_rf_write_en, cu_rf_write_addr, cu_alu_operation, cu_mux_1_sel, cu_rf_addr_b},
                {1'b0, 1'b0, 5'd5, 3'd1, 1'b1, 5'd3});
    @(posedge cu_clk); #1;
    checkOutput("b2b c5", {cu_rf_write_en, cu_done, cu_rf_write_addr}, {1'b1, 1'b1, 5'd5});
    expRetired += 2;
    @(posedge cu_clk); #1;
    checkOutput("b2b retired", cu_retired, expRetired[15:0]);

    // Reset during MEM of a load abandons it and clears the sticky error.
    waitReady("rst mid");
    cu_instr       = 32'h0053B103;
    cu_instr_valid = 1'b1;
    @(posedge cu_clk); #1;
    cu_instr_valid = 1'b0;
    checkOutput("rst mid c1", {cu_rf_write_en, cu_done, cu_error}, {1'b0, 1'b0, 1'b1});
    @(posedge cu_clk); #1;
    checkOutput("rst mid c2", {cu_rf_write_en, cu_dm_write_en, cu_done}, 3'b000);
    cu_reset = 1'b1;
    #1;
    expRetired = 0;
    expError   = 1'b0;
    checkOutput("rst mid asserted", allOut, 106'd0);
    @(posedge cu_clk); #1;
    checkOutput("rst mid held", allOut, 106'd0);
    @(negedge cu_clk);
    cu_reset = 1'b0;
    @(posedge cu_clk); #1;
    checkOutput("rst mid released", allOut, {1'b1, 105'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
